// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with registered read ports and a sticky address-error flag.
// Define REGFILE_WRITE_BYPASS_EN for write-first collisions; the default build is read-first.
module register_file_2r1w #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  RdDataA,
    output logic [WIDTH-1:0]  RdDataB,
    output logic              RdValidA,
    output logic              RdValidB,
    output logic              AddrErr
);

    // One extra bit so DEPTH == 2**ADDR_W still fits in the range comparison.
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wrInRange;
    logic             rdInRangeA;
    logic             rdInRangeB;
    logic             wrHit;
    logic [WIDTH-1:0] rdValueA;
    logic [WIDTH-1:0] rdValueB;

    assign wrInRange  = ({1'b0, WrAddr}  < DEPTH_V);
    assign rdInRangeA = ({1'b0, RdAddrA} < DEPTH_V);
    assign rdInRangeB = ({1'b0, RdAddrB} < DEPTH_V);
    assign wrHit      = WrEn && wrInRange;

    always_comb begin
        rdValueA = '0;
        rdValueB = '0;
        if (rdInRangeA) begin
            rdValueA = regs[RdAddrA];
        end
        if (rdInRangeB) begin
            rdValueB = regs[RdAddrB];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wrHit && rdInRangeA && (WrAddr == RdAddrA)) begin
            rdValueA = WrData;
        end
        if (wrHit && rdInRangeB && (WrAddr == RdAddrB)) begin
            rdValueB = WrData;
        end
`endif
    end

    // Read strobe semantics: RdValidX is high for exactly the cycle after each
    // edge that sampled RdEnX=1 (no ready/backpressure); RdDataX is only
    // reloaded on those edges and otherwise holds its last value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            RdDataA  <= '0;
            RdDataB  <= '0;
            RdValidA <= 1'b0;
            RdValidB <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            if (wrHit) begin
                regs[WrAddr] <= WrData;
            end
            RdValidA <= RdEnA;
            RdValidB <= RdEnB;
            if (RdEnA) begin
                RdDataA <= rdValueA;
            end
            if (RdEnB) begin
                RdDataB <= rdValueB;
            end
            AddrErr <= AddrErr
                     | (WrEn  && !wrInRange)
                     | (RdEnA && !rdInRangeA)
                     | (RdEnB && !rdInRangeB);
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: three shared-stimulus instances (16x8, 16x6, 32x16) checked
// every cycle against an array-based reference model, plus directed literal checks.
module tb_register_file_2r1w;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic        rdEnA;
    logic [3:0]  rdAddrA;
    logic        rdEnB;
    logic [3:0]  rdAddrB;

    logic [15:0] d0A, d0B, d1A, d1B;
    logic [31:0] d2A, d2B;
    logic        v0A, v0B, e0, v1A, v1B, e1, v2A, v2B, e2;

    int checks   = 0;
    int failures = 0;

    register_file_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) uDut8 (
        .CLK(CLK), .RST(rst), .WrEn(wrEn), .WrAddr(wrAddr[2:0]), .WrData(wrData[15:0]),
        .RdEnA(rdEnA), .RdAddrA(rdAddrA[2:0]), .RdEnB(rdEnB), .RdAddrB(rdAddrB[2:0]),
        .RdDataA(d0A), .RdDataB(d0B), .RdValidA(v0A), .RdValidB(v0B), .AddrErr(e0)
    );

    register_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) uDut6 (
        .CLK(CLK), .RST(rst), .WrEn(wrEn), .WrAddr(wrAddr[2:0]), .WrData(wrData[15:0]),
        .RdEnA(rdEnA), .RdAddrA(rdAddrA[2:0]), .RdEnB(rdEnB), .RdAddrB(rdAddrB[2:0]),
        .RdDataA(d1A), .RdDataB(d1B), .RdValidA(v1A), .RdValidB(v1B), .AddrErr(e1)
    );

    register_file_2r1w #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) uDut16 (
        .CLK(CLK), .RST(rst), .WrEn(wrEn), .WrAddr(wrAddr), .WrData(wrData),
        .RdEnA(rdEnA), .RdAddrA(rdAddrA), .RdEnB(rdEnB), .RdAddrB(rdAddrB),
        .RdDataA(d2A), .RdDataB(d2B), .RdValidA(v2A), .RdValidB(v2B), .AddrErr(e2)
    );

    // ---------------- reference model
    typedef struct packed {
        logic [31:0] dA;
        logic [31:0] dB;
        logic        vA;
        logic        vB;
        logic        err;
    } expT;

    expT         expQ[$];
    logic [31:0] mMem   [3][16];
    logic [31:0] mDataA [3];
    logic [31:0] mDataB [3];
    logic        mValidA[3];
    logic        mValidB[3];
    logic        mErr   [3];
    int          mDepth [3] = '{8, 6, 16};
    int          mAddrs [3] = '{8, 8, 16};
    logic [31:0] mMask  [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    expT         modelEntry;

    function automatic logic [31:0] portRead(int k, int ra, logic wHit, int wa, logic [31:0] wd);
        if (ra >= mDepth[k]) return 32'h0;
        if (BYPASS && wHit && (wa == ra)) return wd;
        return mMem[k][ra];
    endfunction

    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            int          wa;
            int          ra;
            int          rb;
            logic [31:0] wd;
            logic        wHit;
            wa   = int'(wrAddr)  % mAddrs[k];
            ra   = int'(rdAddrA) % mAddrs[k];
            rb   = int'(rdAddrB) % mAddrs[k];
            wd   = wrData & mMask[k];
            wHit = wrEn && (wa < mDepth[k]);
            if (rst) begin
                for (int j = 0; j < 16; j++) mMem[k][j] = 32'h0;
                mDataA[k] = 32'h0;  mDataB[k] = 32'h0;
                mValidA[k] = 1'b0;  mValidB[k] = 1'b0;
                mErr[k] = 1'b0;
            end else begin
                mValidA[k] = rdEnA;
                mValidB[k] = rdEnB;
                if (rdEnA) begin
                    mDataA[k] = portRead(k, ra, wHit, wa, wd);
                    if (ra >= mDepth[k]) mErr[k] = 1'b1;
                end
                if (rdEnB) begin
                    mDataB[k] = portRead(k, rb, wHit, wa, wd);
                    if (rb >= mDepth[k]) mErr[k] = 1'b1;
                end
                if (wrEn) begin
                    if (wHit) mMem[k][wa] = wd;
                    else      mErr[k] = 1'b1;
                end
            end
            modelEntry.dA  = mDataA[k];
            modelEntry.dB  = mDataB[k];
            modelEntry.vA  = mValidA[k];
            modelEntry.vB  = mValidB[k];
            modelEntry.err = mErr[k];
            expQ.push_back(modelEntry);
        end
    end

    // ---------------- scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic expT actualOf(int k);
        expT a;
        case (k)
            0:       begin a.dA = {16'h0, d0A}; a.dB = {16'h0, d0B}; a.vA = v0A; a.vB = v0B; a.err = e0; end
            1:       begin a.dA = {16'h0, d1A}; a.dB = {16'h0, d1B}; a.vA = v1A; a.vB = v1B; a.err = e1; end
            default: begin a.dA = d2A;          a.dB = d2B;          a.vA = v2A; a.vB = v2B; a.err = e2; end
        endcase
        return a;
    endfunction

    always @(negedge CLK) begin
        while (expQ.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                expT e;
                expT a;
                e = expQ.pop_front();
                a = actualOf(k);
                check($sformatf("inst%0d_RdDataA", k),  a.dA, e.dA);
                check($sformatf("inst%0d_RdDataB", k),  a.dB, e.dB);
                check($sformatf("inst%0d_RdValidA", k), {31'h0, a.vA}, {31'h0, e.vA});
                check($sformatf("inst%0d_RdValidB", k), {31'h0, a.vB}, {31'h0, e.vB});
                check($sformatf("inst%0d_AddrErr", k),  {31'h0, a.err}, {31'h0, e.err});
            end
        end
    end

    // ---------------- driver
    task automatic step(input logic r, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic ea, input logic [3:0] aa, input logic eb, input logic [3:0] ab);
        rst = r;  wrEn = we;  wrAddr = wa;  wrData = wd;
        rdEnA = ea;  rdAddrA = aa;  rdEnB = eb;  rdAddrB = ab;
        @(negedge CLK);
    endtask

    initial begin
        rst = 1'b1;  wrEn = 1'b0;  wrAddr = 4'd0;  wrData = 32'h0;
        rdEnA = 1'b0;  rdAddrA = 4'd0;  rdEnB = 1'b0;  rdAddrB = 4'd0;
        @(negedge CLK);

        // Reset state: every register reads zero on both ports, no error.
        step(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("reset_RdValidA_idle", {31'h0, v0A}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 1'b1, 4'(i));
            check("reset_RdDataA", {16'h0, d0A}, 32'h0);
            check("reset_RdDataB", {16'h0, d0B}, 32'h0);
            check("reset_RdValidA", {31'h0, v0A}, 32'h1);
            check("reset_AddrErr", {31'h0, e0}, 32'h0);
        end

        // Write two registers, read them on both ports together.
        step(1'b0, 1'b1, 4'd2, 32'h0000_0025, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd5, 32'h0000_0194, 1'b0, 4'd0, 1'b0, 4'd0);
        check("idle_RdValidA", {31'h0, v0A}, 32'h0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b1, 4'd5);
        check("wr_rd_A", {16'h0, d0A}, 32'h0000_0025);
        check("wr_rd_B", {16'h0, d0B}, 32'h0000_0194);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("hold_RdDataA", {16'h0, d0A}, 32'h0000_0025);

        // Same-cycle read/write collision.
        step(1'b0, 1'b1, 4'd3, 32'h0000_1111, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd3, 32'h0000_BEEF, 1'b1, 4'd3, 1'b1, 4'd2);
        check("collide_RdDataA", {16'h0, d0A}, BYPASS ? 32'h0000_BEEF : 32'h0000_1111);
        check("collide_other_B", {16'h0, d0B}, 32'h0000_0025);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0, 4'd0);
        check("after_collide_A", {16'h0, d0A}, 32'h0000_BEEF);

        // Reset wins over a simultaneous write and read.
        step(1'b1, 1'b1, 4'd1, 32'h0000_5A5A, 1'b1, 4'd1, 1'b0, 4'd0);
        check("rst_prio_RdValidA", {31'h0, v0A}, 32'h0);
        check("rst_prio_RdDataA", {16'h0, d0A}, 32'h0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b0, 4'd0);
        check("rst_prio_read1", {16'h0, d0A}, 32'h0);
        check("rst_prio_valid", {31'h0, v0A}, 32'h1);

        // Out-of-range accesses on the 6-deep instance.
        step(1'b0, 1'b1, 4'd7, 32'h0000_AAAA, 1'b1, 4'd6, 1'b0, 4'd0);
        check("oor_RdDataA", {16'h0, d1A}, 32'h0);
        check("oor_RdValidA", {31'h0, v1A}, 32'h1);
        check("oor_AddrErr", {31'h0, e1}, 32'h1);
        check("inrange_AddrErr", {31'h0, e0}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 1'b0, 4'd0);
            check("oor_regs_unchanged", {16'h0, d1A}, 32'h0);
        end
        check("oor_AddrErr_sticky", {31'h0, e1}, 32'h1);

        // Wide instance: top address, full 32-bit data.
        step(1'b0, 1'b1, 4'd15, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 1'b1, 4'd15);
        check("wide_RdDataA", d2A, 32'hDEAD_BEEF);
        check("wide_RdDataB", d2B, 32'hDEAD_BEEF);
        check("wide_AddrErr", {31'h0, e2}, 32'h0);

        // Randomized traffic, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits of every register and data port.
REQ-002 Parameter DEPTH, default 8: number of registers; any value 2..256, not required to be a power of two.
REQ-003 Parameter ADDR_W, default 3: address width in bits; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 WrEn  input  1  write request for the current cycle.
REQ-007 WrAddr  input  ADDR_W  write address.
REQ-008 WrData  input  WIDTH  write data.
REQ-009 RdEnA / RdEnB  input  1 each  read request, port A / port B.
REQ-010 RdAddrA / RdAddrB  input  ADDR_W each  read address, port A / port B.
REQ-011 RdDataA / RdDataB  output  WIDTH each  registered read data, port A / port B.
REQ-012 RdValidA / RdValidB  output  1 each  one-cycle strobe marking fresh read data, port A / port B.
REQ-013 AddrErr  output  1  sticky flag: an out-of-range access has occurred.

Function
REQ-014 A write SHALL update register WrAddr with WrData at the rising edge where WrEn=1 and WrAddr<DEPTH.
REQ-015 A read on port X SHALL have 1-cycle latency: RdEnX=1 at edge N drives RdDataX and RdValidX=1 after edge N.
REQ-016 RdValidX SHALL be 0 after any edge where RdEnX=0.
REQ-017 RdDataX SHALL hold its last value while RdEnX=0.
REQ-018 Ports A and B SHALL operate independently. Both ports reading the same address in one cycle SHALL both return that register's value.
REQ-019 WrEn=1 with WrAddr>=DEPTH SHALL leave all registers unchanged and set AddrErr=1.
REQ-020 RdEnX=1 with RdAddrX>=DEPTH SHALL return all-zeros with RdValidX=1 and set AddrErr=1.
REQ-021 AddrErr SHALL remain 1 until RST; it is cleared only by reset.
REQ-022 Read and write to the same in-range address in the same cycle SHALL follow the Configuration clause. Reads of other addresses SHALL be unaffected.
REQ-023 Back-to-back reads on consecutive cycles SHALL produce RdValidX=1 on consecutive cycles, with no bubble.
REQ-024 Register storage SHALL have no read side effects.

Reset
REQ-025 An edge with RST=1 SHALL set all DEPTH registers to 0, RdDataA=RdDataB=0, RdValidA=RdValidB=0 and AddrErr=0.
REQ-026 RST SHALL take priority over simultaneous WrEn, RdEnA and RdEnB. The write SHALL be discarded and no read strobe issued.
REQ-027 The first edge after RST deasserts SHALL accept writes and reads normally.

Configuration
REQ-028 Macro REGFILE_WRITE_BYPASS_EN SHALL select same-cycle read/write collision behaviour.
REQ-029 With REGFILE_WRITE_BYPASS_EN defined, a read colliding with a write SHALL return the new WrData (write-first).
REQ-030 Without REGFILE_WRITE_BYPASS_EN, a read colliding with a write SHALL return the old register value (read-first). The write still completes.

Verification
REQ-031 Reset check: RST=1 for one edge, then read addresses 0..7 on both ports -> every RdData=0, RdValid=1 one cycle after each request, AddrErr=0.
REQ-032 Write/read check: write 0x0025 to address 2 and 0x0194 to address 5, then read A=2 and B=5 in the same cycle -> RdDataA=0x0025, RdDataB=0x0194 on the next edge.
REQ-033 Collision check: address 3 holds 0x1111; WrEn with WrAddr=3, WrData=0xBEEF while RdEnA=1, RdAddrA=3 -> RdDataA=0xBEEF with the macro, 0x1111 without it; a following read of address 3 returns 0xBEEF in both builds.
REQ-034 Out-of-range check: DEPTH=6; write 0xAAAA to address 7 and read address 6 -> RdData=0, AddrErr=1 and stays 1; all registers unchanged.
REQ-035 Reset priority check: RST=1 together with WrEn (address 1, 0x5A5A) and RdEnA -> RdValidA=0; a later read of address 1 returns 0.
REQ-036 Parameter check: rerun REQ-032 with WIDTH=32, DEPTH=16, ADDR_W=4 using data 0xDEADBEEF at address 15 -> read returns 0xDEADBEEF.
